// File: rtl/pe_ofmap_drain_if.sv
// Handshake bundle for pe_ofmap_drain.
// slave = drain side (psum in, int8 out); master = driving side.
interface pe_ofmap_drain_if #(
  parameter int LANES = 8
) ();
  logic               in_valid;
  logic signed [31:0] in_ofmap [0:LANES-1];
  logic               in_ready;
  logic [4:0]         quant_shift;
  logic               relu_en;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;
  logic               out_last;
  logic               overflow;

  modport slave (
    input  in_valid,
    input  in_ofmap,
    input  quant_shift,
    input  relu_en,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output overflow
  );

  modport master (
    output in_valid,
    output in_ofmap,
    output quant_shift,
    output relu_en,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  overflow
  );
endinterface

// File: rtl/pe_ofmap_drain.sv
// Ofmap drain: buffers psum vectors, serialises lanes as requantised int8.
// Ports: clk, rst (async, active-low), bus (pe_ofmap_drain_if.slave).
module pe_ofmap_drain #(
  parameter int LANES = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  pe_ofmap_drain_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LANES);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  logic [31:0]   r_mem [DEPTH][LANES];
  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;
  logic [31:0]   r_hold [LANES];
  logic [4:0]    r_shift;
  logic          r_relu;
  logic          r_ovf;
  state_t        r_state;
  state_t        w_state_d;
  logic [LW-1:0] r_lane;
  logic [LW-1:0] w_lane_d;

  logic w_pop;
  logic w_push;
  logic w_full;
  logic w_empty;
  logic w_in_ready;
  logic w_last_lane;

  // Extra MSB on the pointers separates full from empty.
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);

  // A pop in the same cycle frees the slot being written.
  assign w_in_ready  = !w_full || w_pop;
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_last_lane = (r_lane == LW'(LANES - 1));

  always_comb begin
    w_state_d = r_state;
    w_lane_d  = r_lane;
    w_pop     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_d = SEND;
          w_lane_d  = '0;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (!w_last_lane) begin
            w_lane_d = r_lane + 1'b1;
          end else begin
            w_lane_d = '0;
            if (!w_empty) begin
              w_pop = 1'b1;
            end else begin
              w_state_d = IDLE;
            end
          end
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int l = 0; l < LANES; l++) begin
        r_mem[r_wp[AW-1:0]][l] <= bus.in_ofmap[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_lane  <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_ovf   <= 1'b0;
      r_shift <= '0;
      r_relu  <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        r_hold[l] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      r_lane  <= w_lane_d;
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (bus.in_valid && !w_in_ready) begin
        r_ovf <= 1'b1;
      end
      // Shift/relu are frozen per vector at pop time.
      if (w_pop) begin
        r_rp    <= r_rp + 1'b1;
        r_shift <= bus.quant_shift;
        r_relu  <= bus.relu_en;
        for (int l = 0; l < LANES; l++) begin
          r_hold[l] <= r_mem[r_rp[AW-1:0]][l];
        end
      end
    end
  end

  logic signed [32:0] w_x;
  logic signed [32:0] w_rnd;
  logic signed [32:0] w_sum;
  logic signed [32:0] w_shr;
  logic signed [7:0]  w_q;

  // Round half up, then arithmetic shift; 33 bits cannot overflow.
  assign w_x   = {r_hold[r_lane][31], r_hold[r_lane]};
  assign w_rnd = (r_shift == 5'd0) ? 33'sd0 :
                 (33'sd1 <<< (r_shift - 5'd1));
  assign w_sum = w_x + w_rnd;
  assign w_shr = w_sum >>> r_shift;

  always_comb begin
    w_q = w_shr[7:0];
    if (r_relu && w_shr[32]) begin
      w_q = 8'sd0;
    end else if (w_shr > 33'sd127) begin
      w_q = 8'sd127;
    end else if (w_shr < -33'sd128) begin
      w_q = -8'sd128;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == SEND);
  assign bus.out_data  = (r_state == SEND) ? w_q : 8'sd0;
  assign bus.out_last  = (r_state == SEND) && w_last_lane;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_pe_ofmap_drain.sv
// Scoreboard bench for pe_ofmap_drain.
// Directed vectors; a negedge monitor pops expected bytes.
module tb_pe_ofmap_drain;
  localparam int LANES = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic signed [7:0] d;
    logic              l;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t exp_q [$];

  logic signed [31:0] vec_in [LANES];
  logic signed [7:0]  exp_out [LANES];

  int p22 [LANES] = '{383, 384, -385, -384,
                      100000, -100000, 127, -129};
  int e22 [LANES] = '{1, 2, -2, -1, 127, -128, 0, -1};
  int e22s0 [LANES] = '{127, 127, -128, -128,
                        127, -128, 127, -128};
  int e23 [LANES] = '{1, 2, 0, 0, 127, 0, 0, 0};

  pe_ofmap_drain_if #(.LANES(LANES)) bus ();

  pe_ofmap_drain #(
    .LANES(LANES),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // Monitor: handshakes pop the scoreboard; stalls must hold.
  logic              stalled;
  logic signed [7:0] prev_d;
  logic              prev_l;

  always @(negedge clk) begin
    if (!rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_data", int'(bus.out_data), int'(prev_d));
        check("stall_last", int'(bus.out_last), int'(prev_l));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", int'(bus.out_data), 999);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", int'(bus.out_data), int'(e.d));
          check("out_last", int'(bus.out_last), int'(e.l));
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      prev_d  = bus.out_data;
      prev_l  = bus.out_last;
    end
  end

  task automatic set_ids(input int id);
    for (int l = 0; l < LANES; l++) begin
      vec_in[l]  = 32'((id * 8 + l) * 256);
      exp_out[l] = 8'(id * 8 + l);
    end
  endtask

  task automatic set_tbl(input int p [LANES], input int e [LANES]);
    for (int l = 0; l < LANES; l++) begin
      vec_in[l]  = 32'(p[l]);
      exp_out[l] = 8'(e[l]);
    end
  endtask

  task automatic push_exp();
    for (int l = 0; l < LANES; l++) begin
      exp_q.push_back('{d: exp_out[l], l: (l == LANES - 1)});
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send(input bit acc);
    bus.in_ofmap = vec_in;
    bus.in_valid = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready", int'(bus.in_ready), int'(acc));
    if (acc) push_exp();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) break;
    end
    check("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_last", int'(bus.out_last), 0);
    check("rst_data", int'(bus.out_data), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int n;
    bit found;
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.quant_shift = 5'd8;
    bus.relu_en = 1'b0;
    for (int l = 0; l < LANES; l++) bus.in_ofmap[l] = '0;
    #6;
    do_reset();

    // Basic vector and 1-cycle latency
    bus.out_ready = 1'b1;
    set_ids(0);
    send(1);
    @(negedge clk);
    check("lat_before", int'(bus.out_valid), 0);
    for (int i = 0; i < LANES; i++) begin
      @(negedge clk);
      check("lat_run", int'(bus.out_valid), 1);
    end
    @(negedge clk);
    check("lat_after", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;

    // Rounding and clamp
    set_tbl(p22, e22);
    send(1);
    wait_drain();
    bus.quant_shift = 5'd0;
    set_tbl(p22, e22s0);
    send(1);
    wait_drain();

    // ReLU
    bus.quant_shift = 5'd8;
    bus.relu_en = 1'b1;
    set_tbl(p22, e23);
    send(1);
    wait_drain();

    // Config change at lane 3 must not affect the vector
    bus.relu_en = 1'b0;
    set_tbl(p22, e22);
    send(1);
    repeat (4) @(posedge clk);
    #1;
    bus.relu_en = 1'b1;
    bus.quant_shift = 5'd0;
    wait_drain();
    bus.relu_en = 1'b0;
    bus.quant_shift = 5'd8;

    // Backpressure and overflow
    do_reset();
    bus.out_ready = 1'b0;
    set_ids(0);
    send(1);
    @(posedge clk);
    #1;
    check("bp_busy", int'(bus.out_valid), 1);
    for (int i = 0; i < DEPTH + 2; i++) begin
      set_ids(i + 1);
      send(i < DEPTH);
    end
    check("bp_ovf", int'(bus.overflow), 1);
    for (int c = 0; c < 2000 && exp_q.size() > 0; c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_drain();
    check("bp_ovf_sticky", int'(bus.overflow), 1);

    // Push and pop while full
    do_reset();
    bus.out_ready = 1'b0;
    set_ids(0);
    send(1);
    @(posedge clk);
    #1;
    for (int i = 1; i <= DEPTH; i++) begin
      set_ids(i);
      send(1);
    end
    @(negedge clk);
    #1;
    check("full_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_last) begin
        found = 1'b1;
        break;
      end
    end
    check("pp_last_seen", int'(found), 1);
    #1;
    set_ids(DEPTH + 1);
    bus.in_ofmap = vec_in;
    bus.in_valid = 1'b1;
    #1;
    check("pp_in_ready", int'(bus.in_ready), 1);
    push_exp();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("pp_ovf", int'(bus.overflow), 0);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus.out_valid) break;
      n++;
    end
    check("pp_run", n, (DEPTH + 1) * LANES);
    check("pp_left", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Reset mid-vector
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ids(i);
      send(1);
    end
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_valid", int'(bus.out_valid), 1);
    do_reset();
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    check("post_rst_quiet", n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
